// File: rtl/sha3_pkg.sv
// Shared SHA3 definitions: mode encoding, block geometry and padding bytes.
package sha3_pkg;

  localparam int STATE_W = 1600;
  localparam int BUF_BYTES = STATE_W / 8;
  localparam logic [7:0] PAD_DS = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_EMIT_PAD = 2'd2
  } state_e;

  // Sponge rate in bytes for each output length; always a multiple of 8.
  function automatic logic [7:0] rate_bytes(input mode_e mode);
    logic [7:0] r;
    case (mode)
      MODE_224: r = 8'd144;
      MODE_256: r = 8'd136;
      MODE_384: r = 8'd104;
      MODE_512: r = 8'd72;
      default:  r = 8'd136;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha3_axis_absorb_padder.sv
// AXI-Stream message packer: gathers bytes into rate-sized blocks, applies
// SHA3 domain padding and presents 1600-bit blocks with valid/ready.
module sha3_axis_absorb_padder
  import sha3_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic [DATA_W/8-1:0]  s_tkeep,
  input  logic                 s_tlast,
  input  logic [1:0]           s_tuser,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [STATE_W-1:0]   m_block,
  output logic [1:0]           m_mode,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int NB = DATA_W / 8;
  localparam logic [7:0] NB_B = 8'(NB);

  state_e               r_state;
  logic [7:0]           r_off;
  logic [STATE_W-1:0]   r_buf;
  mode_e                r_mode;
  logic                 r_last;
  logic                 r_pad;
  logic                 r_valid;
  logic                 r_tready;

  state_e               w_state_n;
  logic [7:0]           w_off_n;
  logic [STATE_W-1:0]   w_buf_n;
  mode_e                w_mode_n;
  logic                 w_last_n;
  logic                 w_pad_n;
  logic [7:0]           w_nbytes;
  logic [7:0]           w_p;
  mode_e                w_cur_mode;
  logic [7:0]           w_rate;
  logic [7:0]           w_rate_emit;

  assign w_cur_mode  = (r_off == 8'd0) ? mode_e'(s_tuser) : r_mode;
  assign w_rate      = rate_bytes(w_cur_mode);
  assign w_rate_emit = rate_bytes(r_mode);
  assign w_p         = r_off + w_nbytes;

  // Valid byte count of the incoming word: full on non-last words, otherwise
  // the index of the lowest clear keep bit (so gaps truncate the word).
  always_comb begin
    w_nbytes = NB_B;
    if (s_tlast) begin
      for (int j = NB - 1; j >= 0; j--) begin
        if (!s_tkeep[j]) w_nbytes = 8'(j);
        else             w_nbytes = w_nbytes;
      end
    end else begin
      w_nbytes = NB_B;
    end
  end

  // Next-state, byte-indexed buffer writes and padding insertion.
  always_comb begin
    logic [7:0]        rel;
    logic [DATA_W-1:0] sh;
    rel       = 8'd0;
    sh        = '0;
    w_state_n = r_state;
    w_off_n   = r_off;
    w_buf_n   = r_buf;
    w_mode_n  = r_mode;
    w_last_n  = r_last;
    w_pad_n   = r_pad;
    case (r_state)
      ST_FILL: begin
        if (s_tvalid) begin
          w_mode_n = w_cur_mode;
          w_off_n  = w_p;
          for (int k = 0; k < BUF_BYTES; k++) begin
            rel = 8'(k) - r_off;
            sh  = s_tdata >> {rel, 3'b000};
            if ((8'(k) >= r_off) && (rel < w_nbytes)) begin
              w_buf_n[8*k +: 8] = sh[7:0];
            end else if (s_tlast && (8'(k) == w_p) && (w_p == w_rate - 8'd1)) begin
              w_buf_n[8*k +: 8] = PAD_DS | PAD_END;
            end else if (s_tlast && (8'(k) == w_p) && (w_p < w_rate - 8'd1)) begin
              w_buf_n[8*k +: 8] = PAD_DS;
            end else if (s_tlast && (8'(k) == w_rate - 8'd1) && (w_p < w_rate - 8'd1)) begin
              w_buf_n[8*k +: 8] = PAD_END;
            end else begin
              w_buf_n[8*k +: 8] = r_buf[8*k +: 8];
            end
          end
          if (s_tlast) begin
            w_state_n = ST_EMIT;
            w_last_n  = (w_p < w_rate);
            w_pad_n   = (w_p == w_rate);
          end else if (w_p == w_rate) begin
            w_state_n = ST_EMIT;
            w_last_n  = 1'b0;
            w_pad_n   = 1'b0;
          end else begin
            w_state_n = ST_FILL;
          end
        end else begin
          w_state_n = ST_FILL;
        end
      end
      ST_EMIT: begin
        if (m_ready) begin
          w_buf_n = '0;
          w_off_n = 8'd0;
          if (r_pad) begin
            // Message ended exactly on a block edge: emit a pure pad block.
            w_buf_n[7:0]                          = PAD_DS;
            w_buf_n[{w_rate_emit - 8'd1, 3'b000} +: 8] = PAD_END;
            w_state_n = ST_EMIT_PAD;
            w_last_n  = 1'b1;
            w_pad_n   = 1'b0;
          end else begin
            w_state_n = ST_FILL;
            w_last_n  = 1'b0;
          end
        end else begin
          w_state_n = ST_EMIT;
        end
      end
      ST_EMIT_PAD: begin
        if (m_ready) begin
          w_buf_n   = '0;
          w_off_n   = 8'd0;
          w_state_n = ST_FILL;
          w_last_n  = 1'b0;
        end else begin
          w_state_n = ST_EMIT_PAD;
        end
      end
      default: begin
        w_state_n = ST_FILL;
        w_buf_n   = '0;
        w_off_n   = 8'd0;
        w_last_n  = 1'b0;
        w_pad_n   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; handshake outputs are registered decodes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= ST_FILL;
      r_off    <= 8'd0;
      r_buf    <= '0;
      r_mode   <= MODE_224;
      r_last   <= 1'b0;
      r_pad    <= 1'b0;
      r_valid  <= 1'b0;
      r_tready <= 1'b1;
    end else begin
      r_state  <= w_state_n;
      r_off    <= w_off_n;
      r_buf    <= w_buf_n;
      r_mode   <= w_mode_n;
      r_last   <= w_last_n;
      r_pad    <= w_pad_n;
      r_valid  <= (w_state_n != ST_FILL);
      r_tready <= (w_state_n == ST_FILL);
    end
  end

  assign m_block  = r_buf;
  assign m_mode   = r_mode;
  assign m_last   = r_last;
  assign m_valid  = r_valid;
  assign s_tready = r_tready;

endmodule

// File: tb/tb_sha3_axis_absorb_padder.sv
// Directed bench for the SHA3 absorb padder at DATA_W=16.
module tb_sha3_axis_absorb_padder;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [15:0]   s_tdata;
  logic [1:0]    s_tkeep;
  logic          s_tlast;
  logic [1:0]    s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic [1599:0] m_block;
  logic [1:0]    m_mode;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [1599:0] e;

  sha3_axis_absorb_padder #(.DATA_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_block(m_block), .m_mode(m_mode), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_block(input string tag, input logic [1599:0] exp);
    for (int i = 0; i < 25; i++)
      check($sformatf("%s_lane%0d", tag, i), m_block[64*i +: 64], exp[64*i +: 64]);
  endtask

  // Called at a negedge; returns at a negedge after the word is accepted.
  task automatic send_word(input logic [15:0] d, input logic [1:0] k,
                           input logic l, input logic [1:0] u);
    int w;
    w = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    while (!s_tready && w < 50) begin
      @(negedge ACLK);
      w++;
    end
    if (w >= 50) check("send_timeout", 64'(w), 64'd0);
    @(negedge ACLK);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Expects a block to be valid immediately, optionally stalls, then accepts it.
  task automatic get_block(input string tag, input logic [1599:0] exp,
                           input logic exp_last, input logic [1:0] exp_mode,
                           input int stall);
    int w;
    logic [1599:0] snap;
    w = 0;
    while (!m_valid && w < 50) begin
      @(negedge ACLK);
      w++;
    end
    check({tag, "_lat"}, 64'(w), 64'd0);
    snap = m_block;
    for (int s = 0; s < stall; s++) begin
      @(negedge ACLK);
      check({tag, "_stall_tready"}, 64'(s_tready), 64'd0);
      check({tag, "_stall_valid"}, 64'(m_valid), 64'd1);
      check({tag, "_stall_hold"}, 64'(m_block === snap), 64'd1);
    end
    check_block(tag, exp);
    check({tag, "_last"}, 64'(m_last), 64'(exp_last));
    check({tag, "_mode"}, 64'(m_mode), 64'(exp_mode));
    m_ready = 1'b1;
    @(negedge ACLK);
    m_ready = 1'b0;
    if (exp_last) check({tag, "_tready_after"}, 64'(s_tready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_last"}, 64'(m_last), 64'd0);
    check({tag, "_mode"}, 64'(m_mode), 64'd0);
    check({tag, "_tready"}, 64'(s_tready), 64'd1);
    check_block({tag, "_blk"}, '0);
  endtask

  initial begin
    ARESET = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    s_tvalid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_reset_state("rst");

    // Empty message, SHA3-256.
    send_word(16'h0000, 2'b00, 1'b1, 2'd1);
    e = '0; e[8*0 +: 8] = 8'h06; e[8*135 +: 8] = 8'h80;
    get_block("empty256", e, 1'b1, 2'd1, 0);

    // Counter message, 16 words, SHA3-256.
    for (int w = 1; w <= 16; w++)
      send_word(16'(w), 2'b11, (w == 16), 2'd1);
    e = '0;
    for (int w = 1; w <= 16; w++) e[8*(2*(w-1)) +: 8] = 8'(w);
    e[8*32 +: 8] = 8'h06; e[8*135 +: 8] = 8'h80;
    get_block("counter", e, 1'b1, 2'd1, 0);

    // Exact fill, SHA3-512: data block then a pure pad block.
    for (int w = 0; w < 36; w++)
      send_word(16'hFFFF, 2'b11, (w == 35), 2'd3);
    e = '0;
    for (int b = 0; b < 72; b++) e[8*b +: 8] = 8'hFF;
    get_block("exact_d", e, 1'b0, 2'd3, 0);
    e = '0; e[8*0 +: 8] = 8'h06; e[8*71 +: 8] = 8'h80;
    get_block("exact_p", e, 1'b1, 2'd3, 0);

    // Rate-1 boundary, SHA3-512: combined 0x86 pad byte.
    for (int w = 0; w < 35; w++)
      send_word(16'h5AA5, 2'b11, 1'b0, 2'd3);
    send_word(16'h00AB, 2'b01, 1'b1, 2'd3);
    e = '0;
    for (int w = 0; w < 35; w++) begin
      e[8*(2*w) +: 8] = 8'hA5; e[8*(2*w+1) +: 8] = 8'h5A;
    end
    e[8*70 +: 8] = 8'hAB; e[8*71 +: 8] = 8'h86;
    get_block("rate_m1", e, 1'b1, 2'd3, 0);

    // Backpressure, SHA3-224, exact fill; tuser changes mid-message.
    for (int w = 0; w < 72; w++)
      send_word(16'(w + 1), 2'b11, (w == 71), (w >= 10) ? 2'd3 : 2'd0);
    e = '0;
    for (int w = 0; w < 72; w++) e[8*(2*w) +: 8] = 8'(w + 1);
    get_block("bp_d", e, 1'b0, 2'd0, 5);
    e = '0; e[8*0 +: 8] = 8'h06; e[8*143 +: 8] = 8'h80;
    get_block("bp_p", e, 1'b1, 2'd0, 5);

    // Reset mid-message, then an empty SHA3-384 message.
    for (int w = 0; w < 10; w++)
      send_word(16'hFFFF, 2'b11, 1'b0, 2'd0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_reset_state("midrst");
    send_word(16'h1234, 2'b00, 1'b1, 2'd2);
    e = '0; e[8*0 +: 8] = 8'h06; e[8*103 +: 8] = 8'h80;
    get_block("after_rst", e, 1'b1, 2'd2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
